uart_line_responder: RTL and testbench
======================================

Name: uart_line_responder

Overview:
- Line-oriented responder that sits on the receive and transmit handshake of the team's byte UART.
- Collects received bytes into an internal line buffer until an end-of-line byte arrives or the buffer fills.
- Then drives the UART transmit handshake to send the buffered line back, followed by the EOL byte.
- Provides the host-facing echo/response path for the Enigma encryptor.
- A later cipher stage is inserted on the tx_byte path.

Parameters:
- DEPTH, 32: line buffer capacity in bytes; power of two, 2..256.
- ADDR_W, 5: log2(DEPTH); also sets the buffer index width.
- EOL, 8'h0D: byte that terminates a line.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset.
- received  in  1  one-cycle pulse from the UART; rx_byte is valid.
- rx_byte  in  8  received byte.
- recv_error  in  1  one-cycle pulse from the UART on a framing error.
- is_transmitting  in  1  UART transmitter busy.
- transmit  out  1  one-cycle request to the UART to send tx_byte.
- tx_byte  out  8  byte to send; held stable from the transmit pulse until is_transmitting falls.
- busy  out  1  high in any state other than COLLECT.
- line_len  out  ADDR_W+1  number of bytes currently buffered, excluding EOL.
- overflow  out  1  sticky flag: line truncated or byte dropped.
- err_count  out  8  saturating count of recv_error pulses.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=COLLECT, transmit=0, tx_byte=8'h00, busy=0, line_len=0, overflow=0, err_count=0. Buffer contents are don't-care.
- COLLECT:
  - received with rx_byte!=EOL and line_len<DEPTH: write buf[line_len]; line_len+1 on the next edge.
  - received with rx_byte==EOL: EOL is not stored; go to ISSUE with rd_idx=0.
  - received with line_len==DEPTH and non-EOL byte: set overflow; go to ISSUE. The byte is dropped.
  - line_len==0 and EOL received: the response is EOL only.
- ISSUE:
  - Wait until is_transmitting==0.
  - Then drive tx_byte = buf[rd_idx], or EOL when rd_idx==line_len.
  - Assert transmit for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for is_transmitting==1. The UART raises it the cycle after sampling transmit. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait for is_transmitting==0.
  - If the byte just sent was EOL: line_len=0, go to COLLECT.
  - Otherwise rd_idx+1, go to ISSUE.
- Timing:
  - Minimum gap between transmit pulses = one UART frame plus 2 cycles.
  - Latency from the EOL received pulse to the first transmit pulse: 1 cycle, given the UART is idle.
- Received bytes while busy=1: dropped and overflow set. Buffer and rd_idx are unchanged.
- recv_error in any state: err_count+1, saturating at 8'hFF. No state change; no byte is stored.
- received and recv_error in the same cycle: both take effect independently.
- rst mid-transmission:
  - Responder returns to COLLECT immediately and transmit is low.
  - A UART frame already in flight completes and is not re-requested.
- overflow clears only on rst.
- line_len width ADDR_W+1 so that the value DEPTH is representable. rd_idx compares against line_len at the same width.
- transmit is never asserted while is_transmitting==1.

Optional Feature:
- Macro: LINE_RESP_UPPERCASE_EN.
- Defined: bytes in range 8'h61..8'h7A are sent minus 8'h20 (uppercased). Conversion is combinational on tx_byte. EOL and all other bytes pass unchanged; the buffer stores raw bytes.
- Undefined: tx_byte carries buffered bytes verbatim.

Test Plan:
- Receive 8'h41,8'h42,8'h0D at 1-frame spacing -> three transmit pulses with tx_byte 8'h41,8'h42,8'h0D in order. Each pulse occurs only after is_transmitting falls; line_len returns to 0.
- Receive a lone 8'h0D -> single transmit with tx_byte=8'h0D; overflow stays 0.
- DEPTH=4; receive 8'h31..8'h35 with no EOL -> 5th byte dropped, overflow=1, sends 8'h31..8'h34 then 8'h0D.
- During the echo of "AB\r", inject received=1 with 8'h58 -> byte absent from output, overflow=1, echo still "AB\r".
- Assert rst two cycles after the first transmit pulse -> transmit stays 0, busy=0, line_len=0. A new "Z\r" then echoes 8'h5A,8'h0D.
- With LINE_RESP_UPPERCASE_EN defined: receive 8'h61,8'h7B,8'h0D -> tx_byte 8'h41,8'h7B,8'h0D. Also: 300 recv_error pulses -> err_count=8'hFF.

Source files
------------

// File: rtl/uart_line_responder.sv
// uart_line_responder: collects received UART bytes into a line buffer until
// an end-of-line byte arrives (or the buffer fills), then echoes the buffered
// line back through the UART transmit handshake, terminated by EOL.
// Optional build macro: LINE_RESP_UPPERCASE_EN (uppercases a..z on tx_byte).
module uart_line_responder #(
    parameter int          DEPTH  = 32,
    parameter int          ADDR_W = 5,
    parameter logic [7:0]  EOL    = 8'h0D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              received,
    input  logic [7:0]        rx_byte,
    input  logic              recv_error,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic [ADDR_W:0]   line_len,
    output logic              overflow,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg;
    logic [7:0]        line_mem [DEPTH];
    logic [7:0]        rd_data_reg;
    logic [ADDR_W:0]   line_len_reg;
    logic [ADDR_W:0]   rd_idx_reg;
    logic [ADDR_W:0]   rd_idx_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        tx_byte_reg;
    logic              transmit_reg;
    logic              sent_eol_reg;
    logic              overflow_reg;
    logic [7:0]        err_count_reg;
    logic              wr_en;

    // Only a non-EOL byte that still fits is written into the buffer.
    assign wr_en = (state_reg == COLLECT) && received && (rx_byte != EOL)
                   && (line_len_reg < DEPTH_L);

    assign rd_idx_next = rd_idx_reg + 1'b1;

    // Prefetch address: the buffer read is registered, so the byte needed on
    // entry to ISSUE is requested one cycle early (index 0 while collecting,
    // the next index while waiting for the current frame to finish).
    always_comb begin
        rd_addr = rd_idx_reg[ADDR_W-1:0];
        if (state_reg == COLLECT) begin
            rd_addr = '0;
        end else if (state_reg == WAIT_IDLE) begin
            rd_addr = rd_idx_next[ADDR_W-1:0];
        end
    end

    // Line buffer: synchronous write, registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[line_len_reg[ADDR_W-1:0]] <= rx_byte;
        end
        rd_data_reg <= line_mem[rd_addr];
    end

    // Control FSM with registered handshake outputs and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= COLLECT;
            transmit_reg  <= 1'b0;
            tx_byte_reg   <= 8'h00;
            sent_eol_reg  <= 1'b0;
            line_len_reg  <= '0;
            rd_idx_reg    <= '0;
            overflow_reg  <= 1'b0;
            err_count_reg <= 8'h00;
        end else begin
            transmit_reg <= 1'b0;

            if (recv_error && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'h01;
            end

            // Bytes arriving while the echo is in progress are discarded.
            if (received && (state_reg != COLLECT)) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                COLLECT: begin
                    if (received) begin
                        if (rx_byte == EOL) begin
                            rd_idx_reg <= '0;
                            state_reg  <= ISSUE;
                        end else if (line_len_reg < DEPTH_L) begin
                            line_len_reg <= line_len_reg + 1'b1;
                        end else begin
                            // Full buffer: drop the byte and flush what we have.
                            overflow_reg <= 1'b1;
                            rd_idx_reg   <= '0;
                            state_reg    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!is_transmitting) begin
                        transmit_reg <= 1'b1;
                        sent_eol_reg <= (rd_idx_reg == line_len_reg);
                        tx_byte_reg  <= (rd_idx_reg == line_len_reg) ? EOL : rd_data_reg;
                        state_reg    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (is_transmitting) begin
                        state_reg <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!is_transmitting) begin
                        if (sent_eol_reg) begin
                            line_len_reg <= '0;
                            state_reg    <= COLLECT;
                        end else begin
                            rd_idx_reg <= rd_idx_next;
                            state_reg  <= ISSUE;
                        end
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

`ifdef LINE_RESP_UPPERCASE_EN
    // Lowercase ASCII letters leave the block uppercased; buffer keeps raw bytes.
    assign tx_byte = ((tx_byte_reg >= 8'h61) && (tx_byte_reg <= 8'h7A) && (tx_byte_reg != EOL))
                     ? (tx_byte_reg - 8'h20) : tx_byte_reg;
`else
    assign tx_byte = tx_byte_reg;
`endif

    assign transmit  = transmit_reg;
    assign busy      = (state_reg != COLLECT);
    assign line_len  = line_len_reg;
    assign overflow  = overflow_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_uart_line_responder.sv
// Directed testbench for uart_line_responder with a simple UART transmitter
// model (busy for FRAME cycles after each accepted transmit pulse).
module tb_uart_line_responder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int FRAME  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              received = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              recv_error = 1'b0;
    logic              is_transmitting = 1'b0;
    logic              transmit;
    logic [7:0]        tx_byte;
    logic              busy;
    logic [ADDR_W:0]   line_len;
    logic              overflow;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    logic hold_ok = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] sent_q [$];
    int pulse_cycle [$];

    uart_line_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .EOL(8'h0D)) dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .busy            (busy),
        .line_len        (line_len),
        .overflow        (overflow),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    // UART transmitter model plus handshake monitor.
    always @(negedge clk) begin
        cyc++;
        if (rst) hold_ok = 1'b0;
        if (busy_cnt > 0) begin
            if (hold_ok) begin
                checks++;
                if (tx_byte !== held) begin
                    errors++;
                    $display("FAIL tx_hold cycle %0d got %h want %h", cyc, tx_byte, held);
                end
            end
            busy_cnt--;
            if (busy_cnt == 0) is_transmitting = 1'b0;
        end
        if (transmit === 1'b1) begin
            checks++;
            if (is_transmitting !== 1'b0) begin
                errors++;
                $display("FAIL tx_while_busy cycle %0d is_transmitting %b want 0", cyc, is_transmitting);
            end
            $display("tx byte %h at cycle %0d", tx_byte, cyc);
            sent_q.push_back(tx_byte);
            pulse_cycle.push_back(cyc);
            held = tx_byte;
            hold_ok = 1'b1;
            is_transmitting = 1'b1;
            busy_cnt = FRAME;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        received = 1'b0;
        $display("rx byte %h", b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_uart_idle();
        int k;
        k = 0;
        while ((is_transmitting !== 1'b0) && k < 200) begin
            @(negedge clk); #1; k++;
        end
    endtask

    task automatic wait_done(input int n, input string name);
        int k;
        k = 0;
        while (!(sent_q.size() >= n && busy === 1'b0 && is_transmitting === 1'b0) && k < 3000) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (sent_q.size() != n || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done bytes %0d busy %b want %0d bytes busy 0", name, sent_q.size(), busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (transmit !== 1'b0)     begin errors++; $display("FAIL reset_transmit got %b want 0", transmit); end
        checks++; if (tx_byte !== 8'h00)     begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (line_len !== 3'd0)     begin errors++; $display("FAIL reset_line_len got %0d want 0", line_len); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (err_count !== 8'h00)   begin errors++; $display("FAIL reset_err_count got %h want 00", err_count); end
    endtask

    task automatic test_basic_line();
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h0D;
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h41);
        repeat (FRAME) @(negedge clk);
        send_byte(8'h42);
        repeat (FRAME) @(negedge clk);
        checks++; if (line_len !== 3'd2) begin errors++; $display("FAIL basic_len got %0d want 2", line_len); end
        send_byte(8'h0D);
        checks++; if (busy !== 1'b1 || transmit !== 1'b0) begin errors++; $display("FAIL basic_issue busy %b transmit %b want 1 0", busy, transmit); end
        @(negedge clk);
        checks++; if (transmit !== 1'b1) begin errors++; $display("FAIL eol_latency transmit %b want 1", transmit); end
        wait_done(3, "basic");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= sent_q.size() || sent_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp[i]);
            end
        end
        for (int i = 1; i < pulse_cycle.size(); i++) begin
            checks++;
            if (pulse_cycle[i] - pulse_cycle[i-1] < FRAME + 2) begin
                errors++;
                $display("FAIL basic_gap%0d got %0d want >= %0d", i, pulse_cycle[i] - pulse_cycle[i-1], FRAME + 2);
            end
        end
        checks++; if (line_len !== 3'd0) begin errors++; $display("FAIL basic_len_end got %0d want 0", line_len); end
    endtask

    task automatic test_lone_eol();
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h0D);
        wait_done(1, "lone");
        checks++; if (sent_q.size() < 1 || sent_q[0] !== 8'h0D) begin errors++; $display("FAIL lone_byte got %h want 0d", (sent_q.size() > 0) ? sent_q[0] : 8'hxx); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL lone_overflow got %b want 0", overflow); end
    endtask

    task automatic test_uppercase();
        logic [7:0] exp [3];
`ifdef LINE_RESP_UPPERCASE_EN
        exp[0] = 8'h41;
`else
        exp[0] = 8'h61;
`endif
        exp[1] = 8'h7B; exp[2] = 8'h0D;
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h61);
        send_byte(8'h7B);
        send_byte(8'h0D);
        wait_done(3, "upper");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= sent_q.size() || sent_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL upper_byte%0d got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        sent_q.delete(); pulse_cycle.delete();
        @(negedge clk);
        received = 1'b1; rx_byte = 8'h51; recv_error = 1'b1;
        @(negedge clk);
        received = 1'b0; recv_error = 1'b0;
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL err_same_cycle got %h want 01", err_count); end
        checks++; if (line_len !== 3'd1) begin errors++; $display("FAIL err_same_cycle_len got %0d want 1", line_len); end
        recv_error = 1'b1;
        repeat (253) @(negedge clk);
        recv_error = 1'b0;
        checks++; if (err_count !== 8'hFE) begin errors++; $display("FAIL err_count_254 got %h want fe", err_count); end
        recv_error = 1'b1;
        @(negedge clk);
        recv_error = 1'b0;
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_count_255 got %h want ff", err_count); end
        recv_error = 1'b1;
        repeat (46) @(negedge clk);
        recv_error = 1'b0;
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_count_sat got %h want ff", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
        send_byte(8'h0D);
        wait_done(2, "err");
        checks++; if (sent_q.size() < 2 || sent_q[0] !== 8'h51 || sent_q[1] !== 8'h0D) begin errors++; $display("FAIL err_echo got %0d bytes want 51 0d", sent_q.size()); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [5];
        exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'h33; exp[3] = 8'h34; exp[4] = 8'h0D;
        do_reset();
        sent_q.delete(); pulse_cycle.delete();
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        checks++; if (line_len !== 3'd4) begin errors++; $display("FAIL ovf_len got %0d want 4", line_len); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        send_byte(8'h35);
        checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ovf_set overflow %b busy %b want 1 1", overflow, busy); end
        wait_done(5, "ovf");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= sent_q.size() || sent_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL ovf_byte%0d got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_drop_while_busy();
        logic [7:0] exp [3];
        int k;
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h0D;
        do_reset();
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
        k = 0;
        while (pulse_cycle.size() < 1 && k < 100) begin @(negedge clk); #1; k++; end
        send_byte(8'h58);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got %b want 1", overflow); end
        wait_done(3, "drop");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= sent_q.size() || sent_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL drop_byte%0d got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
        k = 0;
        while (pulse_cycle.size() < 1 && k < 100) begin @(negedge clk); #1; k++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL mid_transmit got %b want 0", transmit); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (line_len !== 3'd0) begin errors++; $display("FAIL mid_line_len got %0d want 0", line_len); end
        repeat (FRAME + 5) @(negedge clk);
        checks++; if (sent_q.size() != 1) begin errors++; $display("FAIL mid_no_rerequest got %0d pulses want 1", sent_q.size()); end
        wait_uart_idle();
        sent_q.delete(); pulse_cycle.delete();
        send_byte(8'h5A); send_byte(8'h0D);
        wait_done(2, "mid_z");
        checks++; if (sent_q.size() < 2 || sent_q[0] !== 8'h5A || sent_q[1] !== 8'h0D) begin errors++; $display("FAIL mid_z_echo got %0d bytes want 5a 0d", sent_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_lone_eol();
        test_uppercase();
        test_errors();
        test_overflow();
        test_drop_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
